// File: rtl/sobel_pkg.sv
// Shared types and constants for the Sobel 3x3 window controller.
package sobel_pkg;

    localparam int unsigned DEF_PIX_W = 12;
    localparam int unsigned TAP_N     = 9;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    typedef logic [3:0] tap_idx_t;

    // Output tap i takes row-major window element MAP[i]; transpose is its own inverse.
    localparam tap_idx_t ROW_MAP [TAP_N] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
    localparam tap_idx_t TRN_MAP [TAP_N] = '{4'd0, 4'd3, 4'd6, 4'd1, 4'd4, 4'd7, 4'd2, 4'd5, 4'd8};

    function automatic tap_idx_t tap_sel(input tap_idx_t i, input logic trn);
        return trn ? TRN_MAP[i] : ROW_MAP[i];
    endfunction

endpackage

// File: rtl/sobel_line_buf.sv
// One image row of pixel storage; read-before-write on a single address.
module sobel_line_buf #(
    parameter int unsigned DEPTH = 640,
    parameter int unsigned W     = 12,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    input  logic          we,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rd_data_c
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

    assign rd_data_c = mem[addr];

endmodule

// File: rtl/sobel_window_ctrl.sv
// Sequences the registered 3x3 Sobel adder: line buffers, tap window, result strobe.
// Optional SOBEL_TRANSPOSE_EN adds a per-frame transpose input for the vertical gradient.
module sobel_window_ctrl
    import sobel_pkg::*;
#(
    parameter int unsigned IMG_W = 640,
    parameter int unsigned IMG_H = 480,
    parameter int unsigned PIX_W = DEF_PIX_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
`ifdef SOBEL_TRANSPOSE_EN
    input  logic                     transpose,
`endif
    input  logic                     start,
    output logic                     busy,
    output logic                     frame_done,
    input  logic                     s_valid,
    input  logic [PIX_W-1:0]         s_data,
    output logic                     s_ready,
    output logic [PIX_W-1:0]         win_d1,
    output logic [PIX_W-1:0]         win_d2,
    output logic [PIX_W-1:0]         win_d3,
    output logic [PIX_W-1:0]         win_d4,
    output logic [PIX_W-1:0]         win_d5,
    output logic [PIX_W-1:0]         win_d6,
    output logic [PIX_W-1:0]         win_d7,
    output logic [PIX_W-1:0]         win_d8,
    output logic [PIX_W-1:0]         win_d9,
    output logic                     win_valid,
    output logic                     res_valid,
    output logic [$clog2(IMG_W)-1:0] res_x,
    output logic [$clog2(IMG_H)-1:0] res_y
);

    localparam int unsigned XW = $clog2(IMG_W);
    localparam int unsigned YW = $clog2(IMG_H);

    state_t          state;
    logic [XW-1:0]   x;
    logic [YW-1:0]   y;
    logic [XW-1:0]   wx;
    logic [YW-1:0]   wy;
    logic            drain_cnt;
    logic            trn;
    logic            accept;
    logic [PIX_W-1:0] lb0_rd;
    logic [PIX_W-1:0] lb1_rd;
    logic [PIX_W-1:0] win_q [TAP_N];
    logic [PIX_W-1:0] cur   [TAP_N];
    logic [PIX_W-1:0] nxt   [TAP_N];

    assign accept = s_valid & s_ready;

    sobel_line_buf #(.DEPTH(IMG_W), .W(PIX_W), .AW(XW)) u_lb0 (
        .clk       (clk),
        .addr      (x),
        .we        (accept),
        .wdata     (s_data),
        .rd_data_c (lb0_rd)
    );

    sobel_line_buf #(.DEPTH(IMG_W), .W(PIX_W), .AW(XW)) u_lb1 (
        .clk       (clk),
        .addr      (x),
        .we        (accept),
        .wdata     (lb0_rd),
        .rd_data_c (lb1_rd)
    );

`ifdef SOBEL_TRANSPOSE_EN
    logic trn_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                       trn_q <= 1'b0;
        else if (state == IDLE && start)  trn_q <= transpose;
    end

    assign trn = trn_q;
`else
    assign trn = 1'b0;
`endif

    // Recover the row-major view, shift one column left, append the new column.
    always_comb begin
        for (int unsigned i = 0; i < TAP_N; i++) begin
            cur[i] = win_q[tap_sel(tap_idx_t'(i), trn)];
        end
        nxt[0] = cur[1];
        nxt[1] = cur[2];
        nxt[2] = lb1_rd;
        nxt[3] = cur[4];
        nxt[4] = cur[5];
        nxt[5] = lb0_rd;
        nxt[6] = cur[7];
        nxt[7] = cur[8];
        nxt[8] = s_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            s_ready    <= 1'b0;
            win_valid  <= 1'b0;
            res_valid  <= 1'b0;
            res_x      <= '0;
            res_y      <= '0;
            x          <= '0;
            y          <= '0;
            wx         <= '0;
            wy         <= '0;
            drain_cnt  <= 1'b0;
            for (int unsigned i = 0; i < TAP_N; i++) win_q[i] <= '0;
        end else begin
            frame_done <= 1'b0;
            win_valid  <= 1'b0;
            res_valid  <= win_valid;
            if (win_valid) begin
                res_x <= wx;
                res_y <= wy;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= FILL;
                        x       <= '0;
                        y       <= '0;
                        busy    <= 1'b1;
                        s_ready <= 1'b1;
                    end
                end
                FILL, RUN: begin
                    if (accept) begin
                        for (int unsigned i = 0; i < TAP_N; i++) begin
                            win_q[i] <= nxt[tap_sel(tap_idx_t'(i), trn)];
                        end
                        win_valid <= (x >= XW'(2)) && (y >= YW'(2));
                        wx        <= XW'(x - XW'(1));
                        wy        <= YW'(y - YW'(1));
                        if (x == XW'(IMG_W - 1)) begin
                            x <= '0;
                            if (y == YW'(IMG_H - 1)) begin
                                state     <= DRAIN;
                                s_ready   <= 1'b0;
                                drain_cnt <= 1'b0;
                            end else begin
                                y <= YW'(y + YW'(1));
                                if (state == FILL && y == YW'(1)) state <= RUN;
                            end
                        end else begin
                            x <= XW'(x + XW'(1));
                        end
                    end
                end
                // Two cycles let the last window pass through the adder register.
                DRAIN: begin
                    if (drain_cnt) begin
                        state      <= DONE;
                        frame_done <= 1'b1;
                        busy       <= 1'b0;
                    end else begin
                        drain_cnt <= 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign win_d1 = win_q[0];
    assign win_d2 = win_q[1];
    assign win_d3 = win_q[2];
    assign win_d4 = win_q[3];
    assign win_d5 = win_q[4];
    assign win_d6 = win_q[5];
    assign win_d7 = win_q[6];
    assign win_d8 = win_q[7];
    assign win_d9 = win_q[8];

endmodule
